// File: rtl/mux_4to1_rr.sv
// Four-channel round-robin merge with valid/ready on every channel and a
// registered output stage that tags each word with its source index.
module mux_4to1_rr #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic [width-1:0] i2,
    input  logic [width-1:0] i3,
    input  logic             i0_valid,
    input  logic             i1_valid,
    input  logic             i2_valid,
    input  logic             i3_valid,
    output logic             i0_ready,
    output logic             i1_ready,
    output logic             i2_ready,
    output logic             i3_ready,
    output logic [width-1:0] o,
    output logic [1:0]       o_sel,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_dbg_state,
    output logic [1:0]       o_dbg_rr_ptr
);

    // Handshake: a word moves on a rising edge exactly when valid and ready
    // are both high on that channel. ready never looks at the channel's data.

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [width-1:0] r_data;
    logic [1:0]       r_sel;
    logic [1:0]       r_rr_ptr;

    logic [3:0]       w_valid;
    logic [3:0]       w_ready;
    logic             w_load_en;
    logic             w_grant;
    logic [1:0]       w_gnt_idx;
    logic [width-1:0] w_gnt_data;

    assign w_valid   = {i3_valid, i2_valid, i1_valid, i0_valid};
    assign w_load_en = (r_state == ST_EMPTY) | o_ready;

    // First valid channel at or after r_rr_ptr, wrapping modulo 4.
    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_grant && w_valid[r_rr_ptr + 2'(k)]) begin
                w_grant   = 1'b1;
                w_gnt_idx = r_rr_ptr + 2'(k);
            end
        end
        if (!w_load_en || !rst_n) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        w_ready = 4'b0000;
        if (w_grant) begin
            w_ready = 4'b0001 << w_gnt_idx;
        end
    end

    assign i0_ready = w_ready[0];
    assign i1_ready = w_ready[1];
    assign i2_ready = w_ready[2];
    assign i3_ready = w_ready[3];

    always_comb begin
        w_gnt_data = i0;
        case (w_gnt_idx)
            2'd0:    w_gnt_data = i0;
            2'd1:    w_gnt_data = i1;
            2'd2:    w_gnt_data = i2;
            default: w_gnt_data = i3;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (o_ready && !w_grant) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data, tag and pointer only move on a grant, so a held word is bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_sel    <= 2'b00;
            r_rr_ptr <= 2'b00;
        end else if (w_grant) begin
            r_data   <= w_gnt_data;
            r_sel    <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx + 2'd1;
        end
    end

    assign o            = r_data;
    assign o_sel        = r_sel;
    assign o_valid      = (r_state == ST_FULL);
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
